// File: rtl/i2c_txn_arbiter.sv
//==============================================================================
// Module : i2c_txn_arbiter
// Round-robin arbiter sharing one single-byte I2C master between NUM_REQ
// requesters. Optional macro I2C_ARB_TIMEOUT_EN adds a launch-to-done watchdog.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module i2c_txn_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_400,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 m_start_txn,
  output logic                 m_rw,
  output logic [6:0]           m_sub_addr,
  output logic [7:0]           m_data_in,
  input  logic [7:0]           m_data_out,
  input  logic                 m_data_ready,
  input  logic                 m_busy,
  input  logic                 m_done
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESPOND   = 3'd4,
    S_RELEASE   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             rw_q, rw_d;
  logic [6:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             timeout_w;
  logic             err_w;

  // Elaboration-time guard on the supported configuration range
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("i2c_txn_arbiter: parameter out of supported range");
  end

  logic [6:0] addr_arr  [NUM_REQ];
  logic [7:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[7*g +: 7];
    assign wdata_arr[g] = req_wdata[8*g +: 8];
  end

  // Scan starts just after the last winner so the winner drops to lowest priority
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] pick;
  logic             found;

  always_comb begin
    cand  = '0;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = SEL_W'((int'(last_q) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             in_wait;

  assign in_wait = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
  // A done in the same cycle as expiry still counts as a normal completion
  assign timeout_w = in_wait && !m_done && (cnt_d == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_w     = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == S_LAUNCH) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (in_wait) begin
      cnt_d = cnt_q + 1'b1;
      if (timeout_w) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_400 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign timeout_w = 1'b0;
  assign err_w     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          sel_d   = pick;
          rw_d    = req_rw[pick];
          addr_d  = addr_arr[pick];
          wdata_d = wdata_arr[pick];
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        last_d  = sel_q;
        rdata_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (timeout_w)   state_d = S_RESPOND;
        else if (m_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (m_data_ready)         rdata_d = m_data_out;
        if (m_done || timeout_w)  state_d = S_RESPOND;
      end
      S_RESPOND: state_d = S_RELEASE;
      // Hold the command fields until the master is fully idle again
      S_RELEASE: if (!m_done && !m_busy) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_400 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    grant       = '0;
    rsp_valid   = '0;
    m_start_txn = 1'b0;
    rsp_rdata   = 8'h00;
    rsp_err     = 1'b0;
    if (state_q == S_LAUNCH) begin
      grant[sel_q] = 1'b1;
      m_start_txn  = 1'b1;
    end
    if (state_q == S_RESPOND) begin
      rsp_valid[sel_q] = 1'b1;
      rsp_rdata        = (rw_q && !err_w) ? rdata_q : 8'h00;
      rsp_err          = err_w;
    end
  end

  assign m_rw       = rw_q;
  assign m_sub_addr = addr_q;
  assign m_data_in  = wdata_q;

endmodule

`default_nettype wire

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
Round-robin arbiter that shares the single-byte I2C master between NUM_REQ independent requesters.
- Latches one requester's command (address, direction, write byte) and launches it on the master.
- Tracks the master's busy/done/data_ready outputs and returns a per-requester completion pulse with the read byte.
- Sits directly between client blocks and the I2C master, all in the clk_400 domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
TIMEOUT_CYCLES, 1024, clk_400 cycles allowed from launch to master done (used only with the optional feature).

Ports:
clk_400  in  1  clock; the I2C master runs on the same clock.
rst_n  in  1  reset, asynchronous, active-low.
req  in  NUM_REQ  per-requester request level.
req_rw  in  NUM_REQ  per-requester direction: 0 = write, 1 = read.
req_addr  in  7*NUM_REQ  7-bit subordinate address per requester; requester i occupies bits [7i+6:7i].
req_wdata  in  8*NUM_REQ  write byte per requester; requester i occupies bits [8i+7:8i].
grant  out  NUM_REQ  one-hot, one-cycle pulse: command accepted.
rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: transaction finished.
rsp_rdata  out  8  read byte; valid while rsp_valid is high.
rsp_err  out  1  timeout flag; valid while rsp_valid is high.
m_start_txn  out  1  start pulse to the master.
m_rw  out  1  direction to the master.
m_sub_addr  out  7  address to the master.
m_data_in  out  8  write byte to the master.
m_data_out  in  8  read byte from the master.
m_data_ready  in  1  read-byte-valid pulse from the master.
m_busy  in  1  master busy.
m_done  in  1  master done.

Behaviour:
Reset values: grant, rsp_valid, rsp_rdata, rsp_err, m_start_txn, m_rw, m_sub_addr and m_data_in are all 0. State = IDLE. Round-robin pointer last = NUM_REQ-1, so requester 0 wins first.

FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESPOND, RELEASE.
- IDLE: if req != 0, select the first asserted index scanning last+1, last+2, ... (modulo NUM_REQ). Latch sel, req_rw[sel], req_addr[sel] and req_wdata[sel] into m_rw, m_sub_addr and m_data_in. Go to LAUNCH. The arbitration decision is registered, so a requester seen in one IDLE cycle is launched in the next cycle.
- LAUNCH: m_start_txn=1 and grant[sel]=1 for exactly this cycle; last <= sel. Go to WAIT_BUSY.
- WAIT_BUSY: when m_busy=1, go to WAIT_DONE.
- WAIT_DONE:
  - On m_data_ready=1, capture m_data_out into an internal read register.
  - On m_done=1, go to RESPOND.
- RESPOND:
  - rsp_valid[sel]=1 for one cycle.
  - rsp_rdata = captured byte for a read, 0 for a write.
  - rsp_err=0.
  - Go to RELEASE.
- RELEASE: wait until m_done=0 and m_busy=0 (master back in IDLE), then go to IDLE.

Command-field rules:
- m_rw, m_sub_addr and m_data_in stay constant from the IDLE latch until RELEASE exits. The master samples rw and data_in late in the transaction, so these must not change earlier.
- Requester inputs are ignored after latching.

Requester rules:
- Hold req and its fields stable until grant; req may drop the cycle after grant.
- A req withdrawn before grant is never serviced.
- A req still high after rsp_valid is a new transaction.

Arbitration:
- A requester that is granted drops to lowest priority. With all NUM_REQ requesting continuously, grants rotate 0,1,2,3,0,...
- At most one grant and at most one rsp_valid per transaction.
- Requests are not queued; they are re-evaluated only in IDLE.

Reset mid-operation: all outputs return to reset values at once. No rsp_valid is issued for the aborted transaction. The pointer returns to NUM_REQ-1.

Optional Feature:
Macro I2C_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears in LAUNCH and increments each cycle in WAIT_BUSY and WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES-1 before m_done, go to RESPOND with rsp_err=1 and rsp_rdata=0.
  - RELEASE still waits for master idle.
- Not defined: no counter is built and rsp_err is tied to 0.

Test Plan:
- Requester 1 writes (rw=0, addr=0x2A, wdata=0xC3) → grant[1] pulses one cycle after req is seen. m_start_txn pulses once with m_sub_addr=0x2A and m_data_in=0xC3, held until done. rsp_valid[1]=1 with rsp_rdata=0x00.
- Requester 2 reads addr 0x50, subordinate model returns 0xA5 → rsp_valid[2]=1 with rsp_rdata=0xA5. m_rw=1 is held through the master's data_ready pulse.
- req=4'b1111 held for 6 transactions → grant order 0,1,2,3,0,1. No overlap: m_start_txn never pulses while m_busy=1.
- rst_n asserted mid-WAIT_DONE → all outputs 0 in the same cycle. After release, with req=4'b1001, requester 0 is granted first and no rsp_valid is seen for the aborted transaction.
- req[3] pulsed for one cycle while a transaction is in progress → never granted. The next grant goes to the other active requester.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=64, master model never asserts done → rsp_valid[sel]=1 with rsp_err=1 exactly 64 cycles after LAUNCH. Without the macro, rsp_err is 0 in every test.
